systolic_feeder: RTL

Front-end controller for the 4x4 systolic matrix-multiply array. It accepts one pair of 4x4 operand matrices (A, B) per transaction over a valid/ready handshake. It streams them into the array's west and north inputs with the diagonal skew the array requires, holds the array cleared between jobs, and waits for the array's done flag. It then captures the 256-bit product and presents it over a second valid/ready handshake.

---
 rtl/systolic_feeder_if.sv | 34 +++
 rtl/systolic_feeder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Operand/product handshake bundle for systolic_feeder.
// c_err exists only when SYSTOLIC_FEEDER_TIMEOUT_EN is defined.
interface systolic_feeder_if #(
  parameter int unsigned DW = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [16*DW-1:0]  a_data;
  logic [16*DW-1:0]  b_data;
  logic              c_valid;
  logic              c_ready;
  logic [16*DW-1:0]  c_data;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  logic              c_err;
`endif

  // Producer/consumer side
  modport master (
    output in_valid, a_data, b_data, c_ready,
    input  in_ready, c_valid, c_data
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    , input c_err
`endif
  );

  // Feeder side
  modport slave (
    input  in_valid, a_data, b_data, c_ready,
    output in_ready, c_valid, c_data
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    , output c_err
`endif
  );
endinterface

// File: rtl/systolic_feeder.sv
// Front-end controller for a 4x4 systolic matrix-multiply array.
// Latches an A/B pair, streams it with diagonal skew into the array's
// west/north edges, waits for arr_done and presents the product.
// Optional: SYSTOLIC_FEEDER_TIMEOUT_EN adds a 16-cycle DRAIN timeout and c_err.
module systolic_feeder #(
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  bus,
  output logic              arr_rst,
  output logic [DW-1:0]     arr_west0,
  output logic [DW-1:0]     arr_west4,
  output logic [DW-1:0]     arr_west8,
  output logic [DW-1:0]     arr_west12,
  output logic [DW-1:0]     arr_north0,
  output logic [DW-1:0]     arr_north1,
  output logic [DW-1:0]     arr_north2,
  output logic [DW-1:0]     arr_north3,
  input  logic              arr_done,
  input  logic [16*DW-1:0]  arr_out
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

  state_t        state;
  logic [2:0]    k;
  logic [DW-1:0] a_q [4][4];
  logic [DW-1:0] b_q [4][4];
  logic [DW-1:0] w_nxt [4];
  logic [DW-1:0] n_nxt [4];
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  logic [3:0]    dcnt;
`endif

  // Skewed words for the current k: row i lags by i, column j lags by j
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_nxt[i] = '0;
      n_nxt[i] = '0;
      if (k >= 3'(i) && (k - 3'(i)) <= 3'd3) begin
        w_nxt[i] = a_q[i][2'(k - 3'(i))];
        n_nxt[i] = b_q[2'(k - 3'(i))][i];
      end
    end
  end

  // Control FSM with registered handshake, clear and stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      bus.in_ready <= 1'b1;
      bus.c_valid <= 1'b0;
      bus.c_data  <= '0;
      arr_rst     <= 1'b1;
      arr_west0   <= '0;
      arr_west4   <= '0;
      arr_west8   <= '0;
      arr_west12  <= '0;
      arr_north0  <= '0;
      arr_north1  <= '0;
      arr_north2  <= '0;
      arr_north3  <= '0;
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
      dcnt        <= '0;
      bus.c_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            for (int unsigned r = 0; r < 4; r++) begin
              for (int unsigned c = 0; c < 4; c++) begin
                a_q[r][c] <= bus.a_data[16*DW-1-DW*(4*r+c) -: DW];
                b_q[r][c] <= bus.b_data[16*DW-1-DW*(4*r+c) -: DW];
              end
            end
            k            <= '0;
            bus.in_ready <= 1'b0;
            state        <= FEED;
          end
        end
        FEED: begin
          arr_rst    <= 1'b0;
          arr_west0  <= w_nxt[0];
          arr_west4  <= w_nxt[1];
          arr_west8  <= w_nxt[2];
          arr_west12 <= w_nxt[3];
          arr_north0 <= n_nxt[0];
          arr_north1 <= n_nxt[1];
          arr_north2 <= n_nxt[2];
          arr_north3 <= n_nxt[3];
          if (k == 3'd6) begin
            state <= DRAIN;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
            dcnt  <= '0;
`endif
          end else begin
            k <= k + 3'd1;
          end
        end
        DRAIN: begin
          arr_west0  <= '0;
          arr_west4  <= '0;
          arr_west8  <= '0;
          arr_west12 <= '0;
          arr_north0 <= '0;
          arr_north1 <= '0;
          arr_north2 <= '0;
          arr_north3 <= '0;
          if (arr_done) begin
            bus.c_data  <= arr_out;
            bus.c_valid <= 1'b1;
            arr_rst     <= 1'b1;
            state       <= HOLD;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
          end else if (dcnt == 4'd15) begin
            bus.c_data  <= arr_out;
            bus.c_valid <= 1'b1;
            bus.c_err   <= 1'b1;
            arr_rst     <= 1'b1;
            state       <= HOLD;
          end else begin
            dcnt <= dcnt + 4'd1;
`endif
          end
        end
        HOLD: begin
          if (bus.c_ready) begin
            bus.c_valid  <= 1'b0;
            bus.in_ready <= 1'b1;
            state        <= IDLE;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
            bus.c_err    <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
